// File: rtl/elevator_pkg.sv
// elevator_pkg: direction encodings shared with the control FSM and a floor-index width helper.
package elevator_pkg;
  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;
  function automatic int floor_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/call_latch.sv
// call_latch: latches rising edges of call buttons into pending; a clear on the same floor wins.
module call_latch #(
  parameter int N_FLOORS = 3
) (
  input  logic                clk10hz,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] req,
  input  logic [N_FLOORS-1:0] clr,
  output logic [N_FLOORS-1:0] pending
);
  logic [N_FLOORS-1:0] prev;
  // History keeps tracking during reset so buttons held through reset are not seen as new presses.
  always_ff @(posedge clk10hz) prev <= req;
  always_ff @(posedge clk10hz)
    if (rst) pending <= '0;
    else pending <= (pending | (req & ~prev)) & ~clr;
endmodule

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: latches floor calls and picks the next target floor with a LOOK policy.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = 3,
  parameter int FLOOR_W  = floor_w(N_FLOORS)
) (
  input  logic                clk10hz,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] req,
  input  logic [FLOOR_W-1:0]  curr_floor,
  input  logic                arrived,
  output logic [N_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]  target_floor,
  output logic                target_valid,
  output logic [1:0]          dir
);
  dir_t                state, state_n;
  logic [FLOOR_W-1:0]  tgt_n;
  logic                vld_n, valid_c, up_first;
  logic [N_FLOORS-1:0] c_mask;
  logic [FLOOR_W:0]    up, dn, ua, da;
  function automatic logic [FLOOR_W:0] find_up(input logic [N_FLOORS-1:0] p, input logic [FLOOR_W-1:0] c);
    find_up = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--) if (p[i] && i >= int'(c)) find_up = {1'b1, FLOOR_W'(i)};
  endfunction
  function automatic logic [FLOOR_W:0] find_dn(input logic [N_FLOORS-1:0] p, input logic [FLOOR_W-1:0] c);
    find_dn = '0;
    for (int i = 0; i < N_FLOORS; i++) if (p[i] && i <= int'(c)) find_dn = {1'b1, FLOOR_W'(i)};
  endfunction
  assign valid_c = int'(curr_floor) < N_FLOORS;
  assign c_mask  = valid_c ? N_FLOORS'(1) << curr_floor : '0;
  call_latch #(.N_FLOORS(N_FLOORS)) u_latch (
    .clk10hz (clk10hz),
    .rst     (rst),
    .req     (req),
    .clr     (arrived ? c_mask : '0),
    .pending (pending)
  );
  assign up = find_up(pending, curr_floor);
  assign dn = find_dn(pending, curr_floor);
  // Strictly above / below the car: used by IDLE to pick the nearer side, ties going up.
  assign ua = find_up(pending & ~c_mask, curr_floor);
  assign da = find_dn(pending & ~c_mask, curr_floor);
  assign up_first = ua[FLOOR_W] && (!da[FLOOR_W] ||
                    (ua[FLOOR_W-1:0] - curr_floor) <= (curr_floor - da[FLOOR_W-1:0]));
  always_comb begin
    state_n = state;
    tgt_n   = target_floor;
    vld_n   = 1'b0;
    if (valid_c) begin
      vld_n = |pending;
      case (state)
        DIR_IDLE:
          if (pending == c_mask && |pending) tgt_n = curr_floor;
          else if (|pending) begin
            state_n = up_first ? DIR_UP : DIR_DOWN;
            tgt_n   = up_first ? up[FLOOR_W-1:0] : dn[FLOOR_W-1:0];
          end
        DIR_UP: begin
          state_n = up[FLOOR_W] ? DIR_UP : dn[FLOOR_W] ? DIR_DOWN : DIR_IDLE;
          tgt_n   = up[FLOOR_W] ? up[FLOOR_W-1:0] : dn[FLOOR_W] ? dn[FLOOR_W-1:0] : target_floor;
        end
        DIR_DOWN: begin
          state_n = dn[FLOOR_W] ? DIR_DOWN : up[FLOOR_W] ? DIR_UP : DIR_IDLE;
          tgt_n   = dn[FLOOR_W] ? dn[FLOOR_W-1:0] : up[FLOOR_W] ? up[FLOOR_W-1:0] : target_floor;
        end
        default: state_n = DIR_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk10hz)
    if (rst) begin
      state        <= DIR_IDLE;
      target_floor <= '0;
      target_valid <= 1'b0;
    end else begin
      state        <= state_n;
      target_floor <= tgt_n;
      target_valid <= vld_n;
    end
  assign dir = state;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb_elevator_call_scheduler: directed vector table plus randomized run against a behavioural LOOK model.
module tb_elevator_call_scheduler;
  import elevator_pkg::*;
  logic       clk10hz = 0;
  logic       rst = 1, arrived = 0;
  logic [2:0] req = 0, pending;
  logic [1:0] curr_floor = 0, target_floor, dir;
  logic       target_valid;
  int         total = 0, bad = 0;
  always #5 clk10hz = ~clk10hz;
  elevator_call_scheduler #(.N_FLOORS(3), .FLOOR_W(2)) dut (
    .clk10hz      (clk10hz),
    .rst          (rst),
    .req          (req),
    .curr_floor   (curr_floor),
    .arrived      (arrived),
    .pending      (pending),
    .target_floor (target_floor),
    .target_valid (target_valid),
    .dir          (dir)
  );
  typedef struct packed {
    logic       r;
    logic [2:0] rq;
    logic [1:0] cf;
    logic       a;
    logic [2:0] pend;
    logic       vld;
    logic [1:0] dr;
    logic [1:0] tgt;
  } vec_t;
  vec_t tbl[26];
  bit   m_pend[3], m_prev[3];
  int   m_dir, m_tgt;
  bit   m_vld;
  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic [2:0] rq, input logic [1:0] cf, input logic a);
    rst = r; req = rq; curr_floor = cf; arrived = a;
    @(posedge clk10hz);
    #1;
  endtask
  // Reference: the car serves the nearest call, keeps going while calls lie ahead, turns otherwise.
  task automatic model_edge(input bit r, input logic [2:0] rq, input int cf, input bit a);
    int  lo_ge, hi_le, n_up, n_dn, cnt;
    bit  only_here;
    if (r) begin
      foreach (m_pend[f]) begin m_pend[f] = 0; m_prev[f] = rq[f]; end
      m_dir = 0; m_tgt = 0; m_vld = 0;
      return;
    end
    lo_ge = -1; hi_le = -1; n_up = -1; n_dn = -1; cnt = 0;
    for (int f = 0; f < 3; f++) if (m_pend[f]) begin
      cnt++;
      if (f >= cf && lo_ge < 0) lo_ge = f;
      if (f <= cf) hi_le = f;
      if (f > cf && n_up < 0) n_up = f;
      if (f < cf) n_dn = f;
    end
    if (cf >= 3) m_vld = 0;
    else begin
      m_vld = cnt > 0;
      only_here = cnt == 1 && m_pend[cf];
      if (m_dir == 0 && cnt > 0) begin
        if (only_here) m_tgt = cf;
        else if (n_up >= 0 && (n_dn < 0 || n_up - cf <= cf - n_dn)) begin m_dir = 1; m_tgt = lo_ge; end
        else begin m_dir = 2; m_tgt = hi_le; end
      end else if (m_dir == 1) begin
        if (lo_ge >= 0) m_tgt = lo_ge;
        else if (hi_le >= 0) begin m_dir = 2; m_tgt = hi_le; end
        else m_dir = 0;
      end else if (m_dir == 2) begin
        if (hi_le >= 0) m_tgt = hi_le;
        else if (lo_ge >= 0) begin m_dir = 1; m_tgt = lo_ge; end
        else m_dir = 0;
      end
    end
    for (int f = 0; f < 3; f++) begin
      if (rq[f] && !m_prev[f]) m_pend[f] = 1;
      if (a && cf == f) m_pend[f] = 0;
      m_prev[f] = rq[f];
    end
  endtask
  initial begin
    logic [2:0] rq;
    logic [1:0] cf;
    logic       r, a;
    int         mp;
    tbl[0]  = '{1'b1, 3'b111, 2'd0, 1'b0, 3'b000, 1'b0, 2'd0, 2'd0};
    tbl[1]  = '{1'b1, 3'b111, 2'd0, 1'b0, 3'b000, 1'b0, 2'd0, 2'd0};
    tbl[2]  = '{1'b0, 3'b111, 2'd0, 1'b0, 3'b000, 1'b0, 2'd0, 2'd0};
    tbl[3]  = '{1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0, 2'd0, 2'd0};
    tbl[4]  = '{1'b0, 3'b100, 2'd0, 1'b0, 3'b100, 1'b0, 2'd0, 2'd0};
    tbl[5]  = '{1'b0, 3'b000, 2'd0, 1'b0, 3'b100, 1'b1, 2'd1, 2'd2};
    tbl[6]  = '{1'b0, 3'b000, 2'd2, 1'b1, 3'b000, 1'b1, 2'd1, 2'd2};
    tbl[7]  = '{1'b0, 3'b000, 2'd2, 1'b0, 3'b000, 1'b0, 2'd0, 2'd2};
    tbl[8]  = '{1'b0, 3'b101, 2'd1, 1'b0, 3'b101, 1'b0, 2'd0, 2'd2};
    tbl[9]  = '{1'b0, 3'b101, 2'd1, 1'b0, 3'b101, 1'b1, 2'd1, 2'd2};
    tbl[10] = '{1'b0, 3'b101, 2'd2, 1'b1, 3'b001, 1'b1, 2'd1, 2'd2};
    tbl[11] = '{1'b0, 3'b101, 2'd2, 1'b0, 3'b001, 1'b1, 2'd2, 2'd0};
    tbl[12] = '{1'b0, 3'b000, 2'd1, 1'b0, 3'b001, 1'b1, 2'd2, 2'd0};
    tbl[13] = '{1'b0, 3'b000, 2'd0, 1'b1, 3'b000, 1'b1, 2'd2, 2'd0};
    tbl[14] = '{1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0, 2'd0, 2'd0};
    tbl[15] = '{1'b0, 3'b010, 2'd1, 1'b0, 3'b010, 1'b0, 2'd0, 2'd0};
    tbl[16] = '{1'b0, 3'b010, 2'd1, 1'b0, 3'b010, 1'b1, 2'd0, 2'd1};
    tbl[17] = '{1'b0, 3'b000, 2'd1, 1'b1, 3'b000, 1'b1, 2'd0, 2'd1};
    tbl[18] = '{1'b0, 3'b000, 2'd1, 1'b0, 3'b000, 1'b0, 2'd0, 2'd1};
    tbl[19] = '{1'b0, 3'b000, 2'd2, 1'b0, 3'b000, 1'b0, 2'd0, 2'd1};
    tbl[20] = '{1'b0, 3'b101, 2'd2, 1'b1, 3'b001, 1'b0, 2'd0, 2'd1};
    tbl[21] = '{1'b0, 3'b000, 2'd2, 1'b0, 3'b001, 1'b1, 2'd2, 2'd0};
    tbl[22] = '{1'b0, 3'b000, 2'd3, 1'b1, 3'b001, 1'b0, 2'd2, 2'd0};
    tbl[23] = '{1'b0, 3'b010, 2'd3, 1'b0, 3'b011, 1'b0, 2'd2, 2'd0};
    tbl[24] = '{1'b0, 3'b000, 2'd1, 1'b0, 3'b011, 1'b1, 2'd2, 2'd1};
    tbl[25] = '{1'b1, 3'b000, 2'd1, 1'b0, 3'b000, 1'b0, 2'd0, 2'd0};
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].r, tbl[i].rq, tbl[i].cf, tbl[i].a);
      check("pending", i, int'(pending), int'(tbl[i].pend));
      check("valid", i, int'(target_valid), int'(tbl[i].vld));
      check("dir", i, int'(dir), int'(tbl[i].dr));
      check("target", i, int'(target_floor), int'(tbl[i].tgt));
    end
    rq = 0; cf = 0;
    model_edge(1, rq, 0, 0);
    step(1, rq, cf, 0);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 59) == 0;
      if ($urandom_range(0, 2) == 0) rq = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) cf = $urandom_range(0, 11) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom_range(0, 3) == 0;
      model_edge(r, rq, int'(cf), a);
      step(r, rq, cf, a);
      mp = 0;
      for (int f = 0; f < 3; f++) mp += m_pend[f] ? (1 << f) : 0;
      check("rnd_pending", i, int'(pending), mp);
      check("rnd_valid", i, int'(target_valid), int'(m_vld));
      check("rnd_dir", i, int'(dir), m_dir);
      check("rnd_target", i, int'(target_floor), m_tgt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
